jpeg_block_sequencer: RTL and testbench

Per-block control FSM for the JPEG encoder datapath: databuffer load, 2D DCT, DCT capture buffer, row-wise Quantize, zigzag buffer and Huffman encode controller. It generates the strobes and row index that drive these stages in order, one 8x8 block at a time. Upstream offers blocks with a valid/ready handshake. The Huffman controller reports completion with a done pulse.

---
 rtl/jpeg_block_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_jpeg_block_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_block_sequencer.sv
// -----------------------------------------------------------------------------
// jpeg_block_sequencer
//
// Per-block control FSM for the JPEG encoder datapath. For every 8x8 block
// accepted from upstream, it steps through the following stages in order,
// one strobe at a time:
//   1. input databuffer load
//   2. 2D DCT
//   3. DCT result capture
//   4. eight Quantize row slots
//   5. zigzag scan
//   6. Huffman start, then wait for Huffman done
//   7. block done
//
// Optional feature (compile-time macro JPEG_SEQ_TIMEOUT_EN):
//   When defined, a watchdog in HWAIT forces completion after HUFF_TIMEOUT
//   cycles without huff_done and sets the sticky timeout_err flag.
//   When undefined, HWAIT waits forever and timeout_err stays 0.
//
// Parameters:
//   DCT_LATENCY   : cycles dct_enable is held high (1..255)
//   QUANT_LATENCY : Quantize pipeline delay; each row slot lasts
//                   QUANT_LATENCY+1 cycles (0..15)
//   HUFF_TIMEOUT  : watchdog limit in cycles (only with JPEG_SEQ_TIMEOUT_EN)
//
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   block_valid/ready   : upstream block handshake (ready only in IDLE)
//   is_luminance_in/out : component type, latched at accept
//   input_enable        : databuffer load pulse
//   dct_enable          : DCT_2D enable
//   dct_end_enable      : DCT capture pulse
//   matrix_row          : Quantize / zigzag row index (0 outside QUANT)
//   zigzag_input_enable : zigzag row write strobe
//   zigag_enable        : zigzag scan pulse
//   Huffman_start       : Huffman controller start pulse
//   huff_done           : Huffman completion pulse (sampled only in HWAIT)
//   busy                : high whenever not IDLE
//   block_done          : one-cycle completion pulse
//   block_count         : completed blocks (wrapping)
//   timeout_err         : sticky watchdog flag
//
// All outputs are registered from the next-state decode, so each output
// is aligned with the state the FSM occupies in that cycle.
// -----------------------------------------------------------------------------
module jpeg_block_sequencer #(
  parameter int DCT_LATENCY   = 4,
  parameter int QUANT_LATENCY = 1,
  parameter int HUFF_TIMEOUT  = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        block_valid,
  output logic        block_ready,
  input  logic        is_luminance_in,
  output logic        is_luminance,
  output logic        input_enable,
  output logic        dct_enable,
  output logic        dct_end_enable,
  output logic [7:0]  matrix_row,
  output logic        zigzag_input_enable,
  output logic        zigag_enable,
  output logic        Huffman_start,
  input  logic        huff_done,
  output logic        busy,
  output logic        block_done,
  output logic [15:0] block_count,
  output logic        timeout_err
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_DCT    = 4'd2,
    S_CAP    = 4'd3,
    S_QUANT  = 4'd4,
    S_ZZ     = 4'd5,
    S_HSTART = 4'd6,
    S_HWAIT  = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  localparam logic [7:0]  DCT_LAST = 8'(DCT_LATENCY - 1);
  localparam logic [3:0]  Q_LAST   = 4'(QUANT_LATENCY);
  localparam logic [15:0] TO_LAST  = 16'(HUFF_TIMEOUT - 1);

`ifdef JPEG_SEQ_TIMEOUT_EN
  localparam logic TIMEOUT_ON = 1'b1;
`else
  localparam logic TIMEOUT_ON = 1'b0;
`endif

  state_t      state_r, state_s;
  logic [7:0]  dct_cnt_r, dct_cnt_s;
  logic [3:0]  slot_r, slot_s;
  logic [2:0]  row_r, row_s;
  logic [15:0] wd_r, wd_s;
  logic [15:0] count_s;
  logic        lum_s;
  logic        terr_s;

  // Next-state, counter and bookkeeping logic for the block sequence.
  always_comb begin
    state_s   = state_r;
    dct_cnt_s = dct_cnt_r;
    slot_s    = slot_r;
    row_s     = row_r;
    wd_s      = wd_r;
    count_s   = block_count;
    lum_s     = is_luminance;
    terr_s    = timeout_err;
    case (state_r)
      S_IDLE: begin
        if (block_valid && block_ready) begin
          state_s = S_LOAD;
          lum_s   = is_luminance_in;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        state_s   = S_DCT;
        dct_cnt_s = DCT_LAST;
      end
      S_DCT: begin
        // Down-counter loaded with D-1 gives exactly D cycles in DCT.
        if (dct_cnt_r == 8'd0) begin
          state_s = S_CAP;
        end else begin
          dct_cnt_s = dct_cnt_r - 8'd1;
        end
      end
      S_CAP: begin
        state_s = S_QUANT;
        slot_s  = 4'd0;
        row_s   = 3'd0;
      end
      S_QUANT: begin
        // Each row slot is QUANT_LATENCY+1 cycles long.
        if (slot_r == Q_LAST) begin
          slot_s = 4'd0;
          if (row_r == 3'd7) begin
            state_s = S_ZZ;
          end else begin
            row_s = row_r + 3'd1;
          end
        end else begin
          slot_s = slot_r + 4'd1;
        end
      end
      S_ZZ: begin
        state_s = S_HSTART;
      end
      S_HSTART: begin
        state_s = S_HWAIT;
        wd_s    = 16'd0;
      end
      S_HWAIT: begin
        // huff_done wins over a watchdog expiry on the same cycle.
        if (huff_done) begin
          state_s = S_DONE;
          count_s = block_count + 16'd1;
        end else if (TIMEOUT_ON && (wd_r == TO_LAST)) begin
          state_s = S_DONE;
          terr_s  = 1'b1;
        end else if (TIMEOUT_ON) begin
          wd_s = wd_r + 16'd1;
        end else begin
          wd_s = wd_r;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r             <= S_IDLE;
      dct_cnt_r           <= 8'd0;
      slot_r              <= 4'd0;
      row_r               <= 3'd0;
      wd_r                <= 16'd0;
      block_ready         <= 1'b1;
      is_luminance        <= 1'b0;
      input_enable        <= 1'b0;
      dct_enable          <= 1'b0;
      dct_end_enable      <= 1'b0;
      matrix_row          <= 8'd0;
      zigzag_input_enable <= 1'b0;
      zigag_enable        <= 1'b0;
      Huffman_start       <= 1'b0;
      busy                <= 1'b0;
      block_done          <= 1'b0;
      block_count         <= 16'd0;
      timeout_err         <= 1'b0;
    end else begin
      state_r             <= state_s;
      dct_cnt_r           <= dct_cnt_s;
      slot_r              <= slot_s;
      row_r               <= row_s;
      wd_r                <= wd_s;
      block_ready         <= (state_s == S_IDLE);
      is_luminance        <= lum_s;
      input_enable        <= (state_s == S_LOAD);
      dct_enable          <= (state_s == S_DCT);
      dct_end_enable      <= (state_s == S_CAP);
      matrix_row          <= (state_s == S_QUANT) ? {5'd0, row_s} : 8'd0;
      zigzag_input_enable <= (state_s == S_QUANT) && (slot_s == Q_LAST);
      zigag_enable        <= (state_s == S_ZZ);
      Huffman_start       <= (state_s == S_HSTART);
      busy                <= (state_s != S_IDLE);
      block_done          <= (state_s == S_DONE);
      block_count         <= count_s;
      timeout_err         <= terr_s;
    end
  end

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// -----------------------------------------------------------------------------
// tb_jpeg_block_sequencer
//
// Directed test of jpeg_block_sequencer (DCT_LATENCY=4, QUANT_LATENCY=1,
// HUFF_TIMEOUT=16).
//
// A timeline model tracks the cycle index since the accept edge and derives
// every output from the block timing formulas; it is compared every cycle.
// Hand-computed literal checks pin the first block's timeline.
// -----------------------------------------------------------------------------
module tb_jpeg_block_sequencer;

  localparam int D  = 4;
  localparam int Q  = 1;
  localparam int TO = 16;
  localparam int HS = 4 + D + 8 * (Q + 1);  // Huffman_start cycle (24)
  localparam int H0 = HS + 1;               // first HWAIT cycle (25)

`ifdef JPEG_SEQ_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        block_valid;
  logic        block_ready;
  logic        is_luminance_in;
  logic        is_luminance;
  logic        input_enable;
  logic        dct_enable;
  logic        dct_end_enable;
  logic [7:0]  matrix_row;
  logic        zigzag_input_enable;
  logic        zigag_enable;
  logic        Huffman_start;
  logic        huff_done;
  logic        busy;
  logic        block_done;
  logic [15:0] block_count;
  logic        timeout_err;

  jpeg_block_sequencer #(
    .DCT_LATENCY  (D),
    .QUANT_LATENCY(Q),
    .HUFF_TIMEOUT (TO)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .block_valid        (block_valid),
    .block_ready        (block_ready),
    .is_luminance_in    (is_luminance_in),
    .is_luminance       (is_luminance),
    .input_enable       (input_enable),
    .dct_enable         (dct_enable),
    .dct_end_enable     (dct_end_enable),
    .matrix_row         (matrix_row),
    .zigzag_input_enable(zigzag_input_enable),
    .zigag_enable       (zigag_enable),
    .Huffman_start      (Huffman_start),
    .huff_done          (huff_done),
    .busy               (busy),
    .block_done         (block_done),
    .block_count        (block_count),
    .timeout_err        (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  bit          m_active = 1'b0;
  int          m_c      = 0;
  int          m_done_c = 0;
  bit          m_to     = 1'b0;
  logic [15:0] m_count  = 16'd0;
  bit          m_terr   = 1'b0;
  bit          m_lum    = 1'b0;

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_active = 1'b0; m_c = 0; m_done_c = 0; m_to = 1'b0;
        m_count = 16'd0; m_terr = 1'b0; m_lum = 1'b0;
      end else if (!m_active) begin
        if (block_valid) begin
          m_active = 1'b1; m_c = 1; m_done_c = 0; m_to = 1'b0;
          m_lum = is_luminance_in;
        end
      end else if (m_c == m_done_c) begin
        m_active = 1'b0;
      end else begin
        if (m_done_c == 0 && m_c >= H0 && huff_done) begin
          m_done_c = m_c + 1;
        end else if (TO_ON && m_done_c == 0 && m_c == H0 + TO - 1) begin
          m_done_c = m_c + 1;
          m_to = 1'b1;
        end
        m_c++;
        if (m_c == m_done_c) begin
          if (m_to) m_terr = 1'b1;
          else m_count = m_count + 16'd1;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        int  c;
        bit  a, inq;
        int  e_row;
        c   = m_c;
        a   = m_active;
        inq = a && c >= 3 + D && c <= 2 + D + 8 * (Q + 1);
        e_row = inq ? (c - 3 - D) / (Q + 1) : 0;
        chk("cmp_ready", block_ready, !a);
        chk("cmp_busy", busy, a);
        chk("cmp_ie", input_enable, a && c == 1);
        chk("cmp_dct", dct_enable, a && c >= 2 && c <= 1 + D);
        chk("cmp_cap", dct_end_enable, a && c == 2 + D);
        chk("cmp_row", matrix_row, e_row);
        chk("cmp_zzin", zigzag_input_enable, inq && ((c - 3 - D) % (Q + 1)) == Q);
        chk("cmp_zig", zigag_enable, a && c == 3 + D + 8 * (Q + 1));
        chk("cmp_hs", Huffman_start, a && c == HS);
        chk("cmp_done", block_done, a && c == m_done_c);
        chk("cmp_count", block_count, m_count);
        chk("cmp_terr", timeout_err, m_terr);
        chk("cmp_lum", is_luminance, m_lum);
        chk("cmp_onehot", ($countones({input_enable, dct_enable, dct_end_enable,
            zigzag_input_enable, zigag_enable, Huffman_start, block_done}) <= 1), 1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_valid();
    @(negedge clock); block_valid = 1'b1;
    @(negedge clock); block_valid = 1'b0;
  endtask

  task automatic finish_block(input int delay);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      if (Huffman_start) seen = 1'b1;
    end
    chk("hstart_seen", seen, 1);
    if (seen) begin
      repeat (delay) @(negedge clock);
      huff_done = 1'b1;
      @(negedge clock);
      huff_done = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      if (block_ready && !busy) ok = 1'b1;
    end
    chk("idle_reached", ok, 1);
  endtask

  logic       ie_log   [0:31];
  logic       dct_log  [0:31];
  logic       cap_log  [0:31];
  logic [7:0] row_log  [0:31];
  logic       zzin_log [0:31];
  logic       zig_log  [0:31];
  logic       hs_log   [0:31];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b0; block_valid = 1'b0; is_luminance_in = 1'b0; huff_done = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_ready", block_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", block_count, 16'd0);

    // Test 1/2: full timeline of one block, luminance toggled mid-block.
    @(negedge clock); block_valid = 1'b1; is_luminance_in = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clock);
      if (k == 1) begin block_valid = 1'b0; is_luminance_in = 1'b0; end
      ie_log[k] = input_enable;   dct_log[k] = dct_enable;
      cap_log[k] = dct_end_enable; row_log[k] = matrix_row;
      zzin_log[k] = zigzag_input_enable; zig_log[k] = zigag_enable;
      hs_log[k] = Huffman_start;
    end
    chk("t1_ie1", ie_log[1], 1);      chk("t1_ie2", ie_log[2], 0);
    chk("t1_dct1", dct_log[1], 0);    chk("t1_dct2", dct_log[2], 1);
    chk("t1_dct5", dct_log[5], 1);    chk("t1_dct6", dct_log[6], 0);
    chk("t1_cap6", cap_log[6], 1);    chk("t1_row7", row_log[7], 0);
    chk("t1_row9", row_log[9], 1);    chk("t1_row12", row_log[12], 2);
    chk("t1_row22", row_log[22], 7);  chk("t1_zzin7", zzin_log[7], 0);
    chk("t1_zzin8", zzin_log[8], 1);  chk("t1_zzin21", zzin_log[21], 0);
    chk("t1_zzin22", zzin_log[22], 1); chk("t1_zig23", zig_log[23], 1);
    chk("t1_hs23", hs_log[23], 0);    chk("t1_hs24", hs_log[24], 1);
    for (int k = 25; k <= 29; k++) begin
      @(negedge clock);
      if (k == 27) huff_done = 1'b1;
      if (k == 28) begin
        huff_done = 1'b0;
        chk("t2_done", block_done, 1);
        chk("t2_count", block_count, 16'd1);
        chk("t2_lum", is_luminance, 1);
      end
      if (k == 29) chk("t2_ready", block_ready, 1);
    end

    // Test 3: block_valid held across two blocks.
    @(negedge clock); block_valid = 1'b1;
    finish_block(2);
    finish_block(2);
    block_valid = 1'b0;
    wait_idle();
    chk("t3_count", block_count, 16'd3);

    // Test 4: huff_done during QUANT is ignored.
    pulse_valid();
    repeat (9) @(negedge clock);
    huff_done = 1'b1;
    @(negedge clock); huff_done = 1'b0;
    chk("t4_still_busy", busy, 1);
    finish_block(2);
    wait_idle();
    chk("t4_count", block_count, 16'd4);

    // Test 5: reset during QUANT row 3, then a fresh block.
    pulse_valid();
    repeat (12) @(negedge clock);
    chk("t5_row3", matrix_row, 3);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_ready", block_ready, 1);
    chk("t5_rst_strobes", {input_enable, dct_enable, dct_end_enable, zigzag_input_enable,
                           zigag_enable, Huffman_start, block_done, busy}, 0);
    chk("t5_rst_row", matrix_row, 0);
    chk("t5_rst_count", block_count, 16'd0);
    @(negedge clock); #2 reset = 1'b0;
    pulse_valid();
    chk("t5_load", input_enable, 1);
    finish_block(1);
    wait_idle();
    chk("t5_count", block_count, 16'd1);

`ifdef JPEG_SEQ_TIMEOUT_EN
    // Test 6: huff_done on the exact timeout cycle, then a real timeout.
    pulse_valid();
    finish_block(16);
    wait_idle();
    chk("t6_edge_count", block_count, 16'd2);
    chk("t6_edge_terr", timeout_err, 0);
    begin
      bit seen;
      int n;
      seen = 1'b0; n = 0;
      pulse_valid();
      for (int i = 0; i < 300 && !seen; i++) begin
        @(negedge clock);
        if (Huffman_start) seen = 1'b1;
      end
      chk("t6_hstart", seen, 1);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clock);
        n++;
        if (block_done) seen = 1'b1;
      end
      chk("t6_to_delay", n, 17);
    end
    chk("t6_to_count", block_count, 16'd2);
    chk("t6_to_terr", timeout_err, 1);
    wait_idle();
    pulse_valid();
    finish_block(1);
    wait_idle();
    chk("t6_sticky_terr", timeout_err, 1);
    chk("t6_final_count", block_count, 16'd3);
`else
    // Long Huffman wait: no watchdog, no error flag.
    pulse_valid();
    finish_block(20);
    wait_idle();
    chk("t6_long_count", block_count, 16'd2);
    chk("t6_long_terr", timeout_err, 0);
`endif

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
